// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue, busy tracking and decode-stall control for the multiply/divide unit.
// Optional feature macro MDU_DIV0_FAST_EN: a divide by zero finishes after a single busy cycle.
module md_issue_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       e_valid,
    input  logic [3:0] e_op,
    input  logic       e_b_zero,
    input  logic [3:0] d_op,
    output logic       start,
    output logic [3:0] md_op,
    output logic       busy,
    output logic       stall_d,
    output logic       done,
    output logic       drop
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_nxt;
    logic [4:0] w_div_load;

    logic w_e_mul;
    logic w_e_div;
    logic w_e_mfmt;
    logic w_d_md;
    logic w_idle;
    logic w_issue;
    logic w_last;

    always_comb begin
        w_e_mul  = (e_op == OP_MULT) || (e_op == OP_MULTU);
        w_e_div  = (e_op == OP_DIV)  || (e_op == OP_DIVU);
        w_e_mfmt = (e_op >= OP_MFHI) && (e_op <= OP_MTLO);
        w_d_md   = (d_op >= OP_MULT) && (d_op <= OP_MTLO);
        w_idle   = (r_state == S_IDLE);
        w_issue  = e_valid && !req && w_idle;
        w_last   = !w_idle && (r_cnt == 5'd1);
    end

`ifdef MDU_DIV0_FAST_EN
    assign w_div_load = e_b_zero ? 5'd1 : 5'(DIV_CYCLES);
`else
    logic w_unused_b_zero;
    assign w_unused_b_zero = e_b_zero;
    assign w_div_load      = 5'(DIV_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_issue && w_e_mul) begin
                    w_state_nxt = S_MUL;
                    w_cnt_nxt   = 5'(MUL_CYCLES);
                end else if (w_issue && w_e_div) begin
                    w_state_nxt = S_DIV;
                    w_cnt_nxt   = w_div_load;
                end
            end
            S_MUL, S_DIV: begin
                // Flush requests never cut an in-flight operation short.
                if (r_cnt == 5'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        start = 1'b0;
        md_op = '0;
        drop  = 1'b0;
        busy  = !w_idle;
        done  = w_last;
        if (w_issue && (w_e_mul || w_e_div)) begin
            start = 1'b1;
        end
        if (w_issue && (w_e_mul || w_e_div || w_e_mfmt)) begin
            md_op = e_op;
        end
        if (e_valid && !w_idle && (w_e_mul || w_e_div || w_e_mfmt)) begin
            drop = 1'b1;
        end
        // Releasing on done lets the Decode MD op advance into an idle unit with no bubble.
        stall_d = w_d_md && (busy || start) && !done;
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: remaining-cycle reference model plus directed literal checks.
module tb_md_issue_ctrl;

    localparam int unsigned MULC = 5;
    localparam int unsigned DIVC = 10;
`ifdef MDU_DIV0_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       e_valid;
    logic [3:0] e_op;
    logic       e_b_zero;
    logic [3:0] d_op;
    logic       start;
    logic [3:0] md_op;
    logic       busy;
    logic       stall_d;
    logic       done;
    logic       drop;

    int errors = 0;
    int checks = 0;
    int m_left = 0;
    bit m_valid = 1'b0;

    md_issue_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .reset(reset), .req(req), .e_valid(e_valid), .e_op(e_op),
        .e_b_zero(e_b_zero), .d_op(d_op), .start(start), .md_op(md_op),
        .busy(busy), .stall_d(stall_d), .done(done), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_mc(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    function automatic bit is_mf(input logic [3:0] op);
        return (op >= 4'd5) && (op <= 4'd8);
    endfunction

    // Model: m_left = busy cycles still to come, including the current one.
    always @(posedge clk) begin
        if (reset) begin
            m_left  <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (m_left > 0)
                m_left <= m_left - 1;
            else if (e_valid && !req && is_mc(e_op))
                m_left <= (e_op <= 4'd2) ? int'(MULC) : ((FAST && e_b_zero) ? 1 : int'(DIVC));
        end
    end

    always @(negedge clk) begin
        bit         x_busy, x_done, x_issue, x_start, x_drop, x_stall;
        logic [3:0] x_md;
        if (m_valid) begin
            x_busy  = (m_left > 0);
            x_done  = (m_left == 1);
            x_issue = e_valid && !req && !x_busy;
            x_start = x_issue && is_mc(e_op);
            x_md    = (x_issue && (is_mc(e_op) || is_mf(e_op))) ? e_op : 4'd0;
            x_drop  = e_valid && x_busy && (is_mc(e_op) || is_mf(e_op));
            x_stall = (d_op >= 4'd1) && (d_op <= 4'd8) && (x_busy || x_start) && !x_done;
            chk("model_busy", busy, x_busy);
            chk("model_done", done, x_done);
            chk("model_start", start, x_start);
            chk("model_md_op", md_op, x_md);
            chk("model_drop", drop, x_drop);
            chk("model_stall_d", stall_d, x_stall);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [3:0] op, input logic bz,
                       input logic r, input logic [3:0] dop);
        e_valid  = v;
        e_op     = op;
        e_b_zero = bz;
        req      = r;
        d_op     = dop;
    endtask

    initial begin
        int nb;
        int nd;
        reset = 1'b1;
        drv(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_start", start, 0);
        chk("rst_md_op", md_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_drop", drop, 0);
        chk("rst_stall", stall_d, 0);

        // mult: one start pulse, five busy cycles, done on the fifth
        cyc(); drv(1'b1, 4'd1, 1'b0, 1'b0, 4'd0); #1;
        chk("mul_start", start, 1);
        chk("mul_md_op", md_op, 1);
        chk("mul_busy0", busy, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc(); drv(1'b0, 4'd0, 1'b0, 1'b0, 4'd0); #1;
            chk("mul_busy", busy, 1);
            chk("mul_done", done, k == 5);
            chk("mul_nostart", start, 0);
        end
        cyc(); #1;
        chk("mul_idle", busy, 0);

        // div with mflo waiting in Decode
        cyc(); drv(1'b1, 4'd3, 1'b0, 1'b0, 4'd6); #1;
        chk("div_stall_issue", stall_d, 1);
        chk("div_start", start, 1);
        for (int k = 1; k <= 10; k++) begin
            cyc(); drv(1'b0, 4'd0, 1'b0, 1'b0, 4'd6); #1;
            chk("div_busy", busy, 1);
            chk("div_stall", stall_d, k < 10);
            chk("div_done", done, k == 10);
        end
        cyc(); drv(1'b0, 4'd0, 1'b0, 1'b0, 4'd0); #1;
        chk("div_idle", busy, 0);

        // flush blocks issue
        cyc(); drv(1'b1, 4'd1, 1'b0, 1'b1, 4'd0); #1;
        chk("req_start", start, 0);
        chk("req_md_op", md_op, 0);
        chk("req_drop", drop, 0);
        cyc(); drv(1'b0, 4'd0, 1'b0, 1'b0, 4'd0); #1;
        chk("req_busy", busy, 0);

        // single-cycle mf/mt and out-of-range nop
        cyc(); drv(1'b1, 4'd6, 1'b0, 1'b0, 4'd0); #1;
        chk("mf_md_op", md_op, 6);
        chk("mf_start", start, 0);
        cyc(); drv(1'b1, 4'd9, 1'b0, 1'b0, 4'd0); #1;
        chk("nop9_md_op", md_op, 0);
        chk("mf_busy", busy, 0);

        // divu with later ops presented while busy
        cyc(); drv(1'b1, 4'd4, 1'b0, 1'b0, 4'd0); #1;
        chk("divu_md_op", md_op, 4);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 3)      drv(1'b1, 4'd2, 1'b0, 1'b0, 4'd0);
            else if (k == 5) drv(1'b1, 4'd5, 1'b0, 1'b0, 4'd0);
            else if (k == 6) drv(1'b0, 4'd0, 1'b0, 1'b1, 4'd0);
            else             drv(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
            #1;
            chk("divu_busy", busy, 1);
            chk("divu_done", done, k == 10);
            if (k == 3) begin
                chk("drop_mc", drop, 1);
                chk("drop_nostart", start, 0);
                chk("drop_md_op", md_op, 0);
            end
            if (k == 5) begin
                chk("drop_mf", drop, 1);
                chk("drop_mf_md_op", md_op, 0);
            end
        end
        cyc(); drv(1'b0, 4'd0, 1'b0, 1'b0, 4'd0); #1;
        chk("divu_idle", busy, 0);

        // reset on 4th busy cycle aborts without done
        cyc(); drv(1'b1, 4'd3, 1'b0, 1'b0, 4'd0); #1;
        chk("abort_start", start, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc(); drv(1'b0, 4'd0, 1'b0, 1'b0, 4'd0); #1;
            chk("abort_busy", busy, 1);
        end
        reset = 1'b1;
        cyc(); reset = 1'b0; #1;
        chk("abort_busy_after", busy, 0);
        chk("abort_done_after", done, 0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(); #1;
            if (done === 1'b1) nd++;
        end
        chk("abort_no_done", nd, 0);

        // divide by zero
        cyc(); drv(1'b1, 4'd3, 1'b1, 1'b0, 4'd0); #1;
        chk("dz_start", start, 1);
        nb = 0;
        nd = 0;
        for (int k = 0; k < 14; k++) begin
            cyc(); drv(1'b0, 4'd0, 1'b0, 1'b0, 4'd0); #1;
            if (busy === 1'b1) nb++;
            if (done === 1'b1) nd++;
        end
        chk("dz_busy_cycles", nb, FAST ? 1 : 10);
        chk("dz_done_count", nd, 1);

        // randomized traffic checked by the model every cycle
        for (int k = 0; k < 3000; k++) begin
            cyc();
            if ($urandom_range(0, 99) < 2) begin
                reset = 1'b1;
                drv(1'b0, 4'd0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
            end else begin
                reset = 1'b0;
                drv(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                    4'($urandom_range(0, 15)));
            end
        end
        cyc();
        reset = 1'b0;
        drv(1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        repeat (15) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
